regs_wr_arbiter: RTL and testbench

//  Shares the single write port of the 4 x n register file (regs, %0 == 0) between two writers.

---
 rtl/regs_pkg.sv | 21 ++
 rtl/regs_wr_slot.sv | 30 +++
 rtl/regs_wr_arbiter.sv | 116 +++++++++++
 tb/tb_regs_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared types and sizes for the register-file write arbiter.
// Compile-time only; no logic, no latency, no backpressure.
// Widths here must match the arbiter parameters n / R_SIZE.
package regs_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_slot_t;

endpackage

// File: rtl/regs_wr_slot.sv
// One-deep holding register for a single register-file writer.
// Latency: captured at the accepting edge, visible to the arbiter the cycle after.
// Backpressure: ready while empty or while being drained, independent of in_valid.
module regs_wr_slot
    import regs_pkg::*;
(
    input  logic              clk,
    input  logic              n_reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output wr_slot_t          slot
);

    assign in_ready = !slot.valid || drain;

    // An accept on the draining cycle overwrites the slot, so there is no bubble.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            slot <= '0;
        end else if (in_valid && in_ready) begin
            slot <= {1'b1, in_addr, in_data};
        end else if (drain) begin
            slot.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regs_wr_arbiter.sv
// Two-writer arbiter for the single regs write port; REGS_ARB_FIXED_PRIO_EN selects A-priority over round-robin.
// Latency: accept at E0, rf_we registered after E1 when uncontended, one write per cycle.
// Backpressure: x_ready = slot empty or slot granted this cycle; never depends on x_valid.
module regs_wr_arbiter
    import regs_pkg::*;
#(
    parameter int n      = DATA_W,
    parameter int R_SIZE = ADDR_W
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [R_SIZE-1:0]    a_addr,
    input  logic [n-1:0]         a_data,
    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [R_SIZE-1:0]    b_addr,
    input  logic [n-1:0]         b_data,
    output logic                 rf_we,
    output logic [R_SIZE-1:0]    rf_waddr,
    output logic [n-1:0]         rf_wdata,
    output logic [2**R_SIZE-1:0] busy,
    output logic [7:0]           zero_drops
);

    wr_slot_t slot_a, slot_b, win;
    logic     grant_a, grant_b;

    regs_wr_slot u_slot_a (
        .clk      (clk),
        .n_reset  (n_reset),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .in_addr  (a_addr),
        .in_data  (a_data),
        .drain    (grant_a),
        .slot     (slot_a)
    );

    regs_wr_slot u_slot_b (
        .clk      (clk),
        .n_reset  (n_reset),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .in_addr  (b_addr),
        .in_data  (b_data),
        .drain    (grant_b),
        .slot     (slot_b)
    );

`ifdef REGS_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_a = slot_a.valid;
        grant_b = slot_b.valid && !slot_a.valid;
    end
`else
    req_id_t last_grant;

    // On contention the slot that did not win last time goes first.
    always_comb begin
        grant_a = slot_a.valid && (!slot_b.valid || last_grant == REQ_B);
        grant_b = slot_b.valid && (!slot_a.valid || last_grant == REQ_A);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last_grant <= REQ_B;
        end else if (grant_a) begin
            last_grant <= REQ_A;
        end else if (grant_b) begin
            last_grant <= REQ_B;
        end
    end
`endif

    always_comb begin
        win = '0;
        if (grant_a) begin
            win = slot_a;
        end else if (grant_b) begin
            win = slot_b;
        end
    end

    // Writes to %0 consume their grant but never reach the port.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            zero_drops <= '0;
        end else begin
            rf_we <= 1'b0;
            if (win.valid) begin
                if (win.addr != '0) begin
                    rf_we    <= 1'b1;
                    rf_waddr <= win.addr;
                    rf_wdata <= win.data;
                end else if (zero_drops != 8'hFF) begin
                    zero_drops <= zero_drops + 8'd1;
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < 2 ** R_SIZE; r++) begin
            busy[r] = (slot_a.valid && slot_a.addr == R_SIZE'(r))
                   || (slot_b.valid && slot_b.addr == R_SIZE'(r))
                   || (rf_we && rf_waddr == R_SIZE'(r));
        end
    end

endmodule

// File: tb/tb_regs_wr_arbiter.sv
// Directed and random stimulus for regs_wr_arbiter against a transaction-level queue model.
module tb_regs_wr_arbiter;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       a_valid, b_valid;
    logic       a_ready, b_ready;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [3:0] busy;
    logic [7:0] zero_drops;

    always #5 clk = ~clk;

    regs_wr_arbiter dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy),
        .zero_drops (zero_drops)
    );

    // The register file being written, fed only from the DUT write port.
    logic [7:0] tb_rf [4];
    initial for (int i = 0; i < 4; i++) tb_rf[i] = 8'h00;
    always @(posedge clk) if (rf_we) tb_rf[rf_waddr] <= rf_wdata;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } req_t;

    req_t       qa[$];
    req_t       qb[$];
    bit         last_a;
    logic       exp_we;
    logic [1:0] exp_waddr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_drops;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        last_a    = 1'b0;
        exp_we    = 1'b0;
        exp_waddr = 2'd0;
        exp_wdata = 8'h00;
        exp_drops = 8'h00;
    endtask

    // 0: nobody, 1: A, 2: B
    function automatic int pick();
        if (qa.size() != 0 && qb.size() != 0) begin
`ifdef REGS_ARB_FIXED_PRIO_EN
            return 1;
`else
            return last_a ? 2 : 1;
`endif
        end
        if (qa.size() != 0) return 1;
        if (qb.size() != 0) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] exp_busy();
        logic [3:0] b = 4'b0;
        foreach (qa[i]) b[qa[i].addr] = 1'b1;
        foreach (qb[i]) b[qb[i].addr] = 1'b1;
        if (exp_we) b[exp_waddr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic commit(input req_t r);
        if (r.addr != 2'd0) begin
            exp_we    = 1'b1;
            exp_waddr = r.addr;
            exp_wdata = r.data;
        end else begin
            exp_we = 1'b0;
            if (exp_drops != 8'hFF) exp_drops = exp_drops + 8'd1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".we"},    rf_we,      exp_we);
        chk({tag, ".waddr"}, rf_waddr,   exp_waddr);
        chk({tag, ".wdata"}, rf_wdata,   exp_wdata);
        chk({tag, ".busy"},  busy,       exp_busy());
        chk({tag, ".drops"}, zero_drops, exp_drops);
    endtask

    // Called just after a rising edge with inputs already driven for the next edge.
    task automatic cycle(input string tag);
        int   g;
        bit   ra, rb, acc_a, acc_b;
        req_t na, nb;
        g  = pick();
        ra = (qa.size() == 0) || (g == 1);
        rb = (qb.size() == 0) || (g == 2);
        #1;
        chk({tag, ".a_ready"}, a_ready, ra);
        chk({tag, ".b_ready"}, b_ready, rb);
        acc_a = a_valid && ra;
        acc_b = b_valid && rb;
        na = '{addr: a_addr, data: a_data};
        nb = '{addr: b_addr, data: b_data};
        @(posedge clk);
        if (g == 1) begin
            commit(qa.pop_front());
            last_a = 1'b1;
        end else if (g == 2) begin
            commit(qb.pop_front());
            last_a = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (acc_a) qa.push_back(na);
        if (acc_b) qb.push_back(nb);
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input logic av, input logic [1:0] aa, input logic [7:0] ad,
                         input logic bv, input logic [1:0] ba, input logic [7:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic idle(input string tag, input int cycles);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        for (int i = 0; i < cycles; i++) cycle(tag);
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        n_reset = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
    endtask

    initial begin
        n_reset = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        model_reset();
        #2;
        @(posedge clk);
        #1;

        // 1: A alone writes r1 = 07
        do_reset("t1_rst");
        drive(1'b1, 2'd1, 8'h07, 1'b0, 2'd0, 8'h00);
        cycle("t1_acc");
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        cycle("t1_we");
        chk("t1_we_direct", {rf_we, rf_waddr, rf_wdata}, {1'b1, 2'd1, 8'h07});
        cycle("t1_commit");
        chk("t1_busy1_clear", busy[1], 1'b0);
        idle("t1_idle", 1);
        chk("t1_rf1", tb_rf[1], 8'h07);

        // 2: A r2=06 and B r3=05 together; A first then B back to back
        do_reset("t2_rst");
        drive(1'b1, 2'd2, 8'h06, 1'b1, 2'd3, 8'h05);
        cycle("t2_acc");
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        cycle("t2_w1");
        chk("t2_first", {rf_we, rf_waddr, rf_wdata}, {1'b1, 2'd2, 8'h06});
        cycle("t2_w2");
        chk("t2_second", {rf_we, rf_waddr, rf_wdata}, {1'b1, 2'd3, 8'h05});
        idle("t2_idle", 2);

        // 3: both held valid for 6 cycles
        do_reset("t3_rst");
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'd1, 8'h10 + 8'(i), 1'b1, 2'd2, 8'h20 + 8'(i));
            cycle("t3_hold");
        end
        idle("t3_idle", 3);

        // 4: %0 writes are dropped and counted, saturating at FF
        do_reset("t4_rst");
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hAA);
        for (int i = 0; i < 3; i++) cycle("t4_zero");
        idle("t4_idle", 2);
        chk("t4_drops3", zero_drops, 8'd3);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'hAA);
        for (int i = 0; i < 297; i++) cycle("t4_zero_sat");
        idle("t4_idle2", 2);
        chk("t4_drops_sat", zero_drops, 8'hFF);

        // 5: same-address writes; B granted second and its data remains
        do_reset("t5_rst");
        drive(1'b1, 2'd3, 8'h04, 1'b1, 2'd3, 8'h03);
        cycle("t5_acc");
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        cycle("t5_w1");
        cycle("t5_w2");
        chk("t5_busy3_pending", busy[3], 1'b1);
        idle("t5_idle", 2);
        chk("t5_rf3", tb_rf[3], 8'h03);

        // 6: reset with both slots full discards everything
        do_reset("t6_rst");
        drive(1'b1, 2'd1, 8'h11, 1'b1, 2'd2, 8'h22);
        cycle("t6_acc");
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
        #1;
        n_reset = 1'b0;
        model_reset();
        #1;
        check_outputs("t6_in_reset");
        chk("t6_busy_zero", busy, 4'b0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        idle("t6_after", 4);

        // Random traffic
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
            cycle("rnd");
        end
        idle("rnd_idle", 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
